dense_layer_mac: RTL and testbench
==================================

Name: dense_layer_mac

Overview:
Parametrised fully-connected layer engine, the generalised successor of the fixed 24-in/64-out LAYER1 block in the PPG-to-CO network. It captures one input vector and computes N_OUT signed fixed-point dot products plus bias, using N_MAC parallel multiply-accumulate lanes. Each result is scaled, saturated and optionally ReLU-activated, then held under a valid/ready handshake. Weights and biases live in internal register arrays and are written through a load port, so one RTL serves every dense layer.

Parameters:
N_IN, 24, input vector length (>=1)
N_OUT, 64, output vector length (N_OUT % N_MAC == 0)
N_MAC, 4, parallel MAC lanes; G = N_OUT/N_MAC output groups
DATA_W, 16, signed width of input/weight/bias/output
FRAC_BITS, 8, fractional bits of Q-format (0 allowed)
ACT_MODE, 1, 0 = linear, 1 = ReLU

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request a run; sampled only in IDLE
input_data  in  DATA_W x N_IN  signed input vector (unpacked array), captured on accepted start
ready  in  1  downstream accepts output_data
output_data  out  DATA_W x N_OUT  signed results (unpacked array)
valid  out  1  output_data complete and stable
busy  out  1  high from accepted start until handshake completes
sat_flag  out  1  at least one output saturated in the current/last run
w_we  in  1  weight write strobe
w_addr  in  clog2(N_OUT*N_IN)  weight index = o*N_IN + i
w_data  in  DATA_W  signed weight
b_we  in  1  bias write strobe
b_addr  in  clog2(N_OUT)  bias index
b_data  in  DATA_W  signed bias

Behaviour:
- Reset (reset low, asynchronous): state IDLE; valid=0, busy=0, sat_flag=0, all output_data=0, counters=0. Weight/bias arrays are not reset and keep their contents across reset.
- States: IDLE, MAC, STORE, DONE.
- IDLE: start=1 at edge T0 -> capture input_data, group g=0, k=0, each lane accumulator = bias[g*N_MAC+lane] << FRAC_BITS. Clear sat_flag, set busy, go to MAC.
- MAC: each edge, lane L does acc += x[k]*w[(g*N_MAC+L)*N_IN + k] and k increments. After k=N_IN-1, go to STORE.
- STORE (one edge): result = acc >>> FRAC_BITS (arithmetic, truncate toward -inf). Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and set sat_flag if clipped. If ACT_MODE=1, negative results become 0, applied after saturation. Write to output_data[g*N_MAC+L] and increment g. If g was G-1, go to DONE and set valid; otherwise reload accumulators with the next biases, k=0, go to MAC.
- Accumulator width: 2*DATA_W + clog2(N_IN) + 1; no internal overflow.
- Latency: valid is high after edge T0 + G*(N_IN+1). Defaults: 400 cycles.
- DONE: valid=1 and output_data stable for as long as ready=0. On an edge with ready=1: valid=0, busy=0, go to IDLE. A start in that same cycle is ignored.
- start is ignored in MAC, STORE and DONE. Inputs are used only from the captured copy.
- output_data changes only in STORE, so results from the previous run persist until overwritten.
- w_we/b_we take effect in IDLE and DONE only and are dropped while in MAC or STORE. When both strobes are set, both writes occur.
- Reset asserted mid-run aborts immediately to the reset values above.

Test Plan:
- Reset: hold reset low 10 cycles -> valid=0, busy=0, sat_flag=0, every output_data=0.
- Functional run with defaults: inputs 85,226,137,122,342,281,228,70,168,466,208,22,22,146,134,57,59,219,83,102,59,156,30,22; row 0 weights all 256, bias 0; other rows weights 0, bias[o]=o -> output_data[0]=3444, output_data[o]=o for o>=1. valid rises exactly 400 cycles after the start edge; sat_flag=0.
- Saturation/activation: all inputs 32767 and weights 32767 -> every output 32767, sat_flag=1. Weights -32768 with ACT_MODE=0 -> -32768; same with ACT_MODE=1 -> 0.
- Truncation: single input -1, weight 1, bias 0, ACT_MODE=0 -> output -1 (floor). Input 255, weight 1 -> 0.
- Handshake: hold ready=0 for 1000 cycles after valid -> valid and output_data unchanged, while start pulses and weight writes in MAC are ignored. Raise ready -> valid and busy fall on the next edge; a following start begins a new run.
- Reset mid-run: assert reset at MAC cycle 100 -> valid=0, busy=0, outputs=0 at once. Release and rerun the functional test without reloading weights -> same 3444 / o results.

Source files
------------

// File: rtl/dense_layer_mac.sv
// Parametrised dense-layer engine: N_MAC lanes build N_OUT bias + dot-product sums group by group,
// then scale, saturate, optionally ReLU, and hold the vector under a valid/ready handshake.
module dense_layer_mac #(
  parameter int N_IN      = 24,
  parameter int N_OUT     = 64,
  parameter int N_MAC     = 4,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACT_MODE  = 1,
  localparam int WA_W     = (N_OUT * N_IN > 1) ? $clog2(N_OUT * N_IN) : 1,
  localparam int BA_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] input_data [N_IN],
  input  logic                     ready,
  output logic signed [DATA_W-1:0] output_data [N_OUT],
  output logic                     valid,
  output logic                     busy,
  output logic                     sat_flag,
  input  logic                     w_we,
  input  logic [WA_W-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic                     b_we,
  input  logic [BA_W-1:0]          b_addr,
  input  logic signed [DATA_W-1:0] b_data
);

  localparam int G     = N_OUT / N_MAC;
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACC_W = 2 * DATA_W + $clog2(N_IN) + 1;

  // Saturation bounds, sign-extended to accumulator width for direct comparison.
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic signed [DATA_W-1:0] RES_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [DATA_W-1:0] RES_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    STORE,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  x_q   [N_IN];
  logic signed [DATA_W-1:0]  x_d   [N_IN];
  logic signed [ACC_W-1:0]   acc_q [N_MAC];
  logic signed [ACC_W-1:0]   acc_d [N_MAC];
  logic signed [DATA_W-1:0]  out_q [N_OUT];
  logic signed [DATA_W-1:0]  out_d [N_OUT];
  logic [GW-1:0]             g_q, g_d;
  logic [KW-1:0]             k_q, k_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      sat_q, sat_d;

  logic signed [DATA_W-1:0]  w_mem [N_OUT * N_IN];
  logic signed [DATA_W-1:0]  b_mem [N_OUT];

  logic                      cfg_open;
  logic                      w_wr;
  logic                      b_wr;

  logic [WA_W-1:0]           w_idx;
  logic [BA_W-1:0]           o_idx;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [DATA_W-1:0]  res;
  logic                      clip;

  // Coefficients may only change while no run is consuming them.
  assign cfg_open = (state_q == IDLE) || (state_q == DONE);
  assign w_wr     = w_we && cfg_open && (int'(w_addr) < N_OUT * N_IN);
  assign b_wr     = b_we && cfg_open && (int'(b_addr) < N_OUT);

  // NOTE: coefficient arrays deliberately have no reset: they must survive reset and stay plain storage.
  always_ff @(posedge clk) begin
    if (w_wr) w_mem[w_addr] <= w_data;
    if (b_wr) b_mem[b_addr] <= b_data;
  end

  function automatic logic signed [ACC_W-1:0] bias_init(input logic signed [DATA_W-1:0] b);
    logic signed [ACC_W-1:0] ext;
    ext = ACC_W'(b);
    return ext <<< FRAC_BITS;
  endfunction

  // NOTE: every variable gets its default before the case so no path can leave one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    out_d   = out_q;
    g_d     = g_q;
    k_d     = k_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    sat_d   = sat_q;
    w_idx   = '0;
    o_idx   = '0;
    shifted = '0;
    res     = '0;
    clip    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d = input_data;
          g_d = '0;
          k_d = '0;
          for (int l = 0; l < N_MAC; l++) begin
            acc_d[l] = bias_init(b_mem[BA_W'(l)]);
          end
          sat_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end

      MAC: begin
        for (int l = 0; l < N_MAC; l++) begin
          w_idx    = WA_W'((int'(g_q) * N_MAC + l) * N_IN + int'(k_q));
          acc_d[l] = acc_q[l] + ACC_W'(x_q[k_q]) * ACC_W'(w_mem[w_idx]);
        end
        if (k_q == KW'(N_IN - 1)) begin
          k_d     = '0;
          state_d = STORE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      STORE: begin
        for (int l = 0; l < N_MAC; l++) begin
          o_idx   = BA_W'(int'(g_q) * N_MAC + l);
          shifted = acc_q[l] >>> FRAC_BITS;
          clip    = 1'b0;
          if (shifted > OUT_MAX) begin
            res  = RES_MAX;
            clip = 1'b1;
          end else if (shifted < OUT_MIN) begin
            res  = RES_MIN;
            clip = 1'b1;
          end else begin
            res = shifted[DATA_W-1:0];
          end
          // ReLU acts on the already-saturated value.
          if (ACT_MODE == 1 && res[DATA_W-1]) res = '0;
          out_d[o_idx] = res;
          if (clip) sat_d = 1'b1;
        end
        if (g_q == GW'(G - 1)) begin
          g_d     = '0;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          g_d = g_q + GW'(1);
          k_d = '0;
          for (int l = 0; l < N_MAC; l++) begin
            acc_d[l] = bias_init(b_mem[BA_W'((int'(g_q) + 1) * N_MAC + l)]);
          end
          state_d = MAC;
        end
      end

      DONE: begin
        if (ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < N_IN; i++)  x_q[i]   <= '0;
      for (int l = 0; l < N_MAC; l++) acc_q[l] <= '0;
      for (int o = 0; o < N_OUT; o++) out_q[o] <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      sat_q   <= sat_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign output_data = out_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign sat_flag    = sat_q;

endmodule

// File: tb/tb_dense_layer_mac.sv
// Scoreboard bench for dense_layer_mac: a ReLU instance and a linear instance share all stimulus,
// expected vectors come from a behavioural model of the layer and are checked when valid rises.
module tb_dense_layer_mac;

  localparam int N_IN  = 24;
  localparam int N_OUT = 64;
  localparam int FRAC  = 8;
  localparam int BOUND = 3000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic w_we = 1'b0;
  logic b_we = 1'b0;
  logic [10:0] w_addr = '0;
  logic [5:0]  b_addr = '0;
  logic signed [15:0] w_data = '0;
  logic signed [15:0] b_data = '0;
  logic signed [15:0] in_vec [N_IN];
  logic signed [15:0] out_a [N_OUT];
  logic signed [15:0] out_l [N_OUT];
  logic valid_a, busy_a, sat_a;
  logic valid_l, busy_l, sat_l;

  int tb_w [N_OUT*N_IN];
  int tb_b [N_OUT];
  int tb_x [N_IN];
  int func_x [N_IN] = '{85, 226, 137, 122, 342, 281, 228, 70, 168, 466, 208, 22,
                        22, 146, 134, 57, 59, 219, 83, 102, 59, 156, 30, 22};

  int exp_a [$];
  int exp_l [$];
  bit exp_sat [$];
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dense_layer_mac #(.ACT_MODE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .input_data(in_vec), .ready(ready),
    .output_data(out_a), .valid(valid_a), .busy(busy_a), .sat_flag(sat_a),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data)
  );

  dense_layer_mac #(.ACT_MODE(0)) dut_lin (
    .clk(clk), .reset(reset), .start(start), .input_data(in_vec), .ready(ready),
    .output_data(out_l), .valid(valid_l), .busy(busy_l), .sat_flag(sat_l),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data)
  );

  function automatic int model_out(input int o, input bit relu, output bit clip);
    longint acc;
    longint r;
    acc = longint'(tb_b[o]) * (longint'(1) << FRAC);
    for (int i = 0; i < N_IN; i++) acc += longint'(tb_x[i]) * longint'(tb_w[o*N_IN + i]);
    r = acc >>> FRAC;
    clip = 1'b0;
    if (r > 32767) begin
      r = 32767;
      clip = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      clip = 1'b1;
    end
    if (relu && r < 0) r = 0;
    return int'(r);
  endfunction

  task automatic push_expected();
    bit c;
    bit any_clip;
    any_clip = 1'b0;
    for (int o = 0; o < N_OUT; o++) begin
      exp_a.push_back(model_out(o, 1'b1, c));
      any_clip |= c;
      exp_l.push_back(model_out(o, 1'b0, c));
    end
    exp_sat.push_back(any_clip);
  endtask

  task automatic scoreboard_compare(input string name);
    int ea, el;
    bit es;
    total_cnt++;
    if (exp_a.size() < N_OUT || exp_sat.size() == 0) begin
      $display("FAIL %s: scoreboard holds %0d entries, need %0d", name, exp_a.size(), N_OUT);
      return;
    end
    pass_cnt++;
    for (int o = 0; o < N_OUT; o++) begin
      ea = exp_a.pop_front();
      el = exp_l.pop_front();
      total_cnt += 2;
      if (int'(out_a[o]) !== ea) $display("FAIL %s relu out[%0d]: got %0d expected %0d", name, o, out_a[o], ea);
      else pass_cnt++;
      if (int'(out_l[o]) !== el) $display("FAIL %s linear out[%0d]: got %0d expected %0d", name, o, out_l[o], el);
      else pass_cnt++;
    end
    es = exp_sat.pop_front();
    total_cnt++;
    if (sat_a !== es || sat_l !== es) $display("FAIL %s sat_flag: got %b/%b expected %b", name, sat_a, sat_l, es);
    else pass_cnt++;
  endtask

  task automatic load_coeffs();
    for (int i = 0; i < N_OUT*N_IN; i++) begin
      w_we = 1'b1;
      w_addr = 11'(i);
      w_data = 16'(tb_w[i]);
      b_we = (i < N_OUT);
      b_addr = 6'(i % N_OUT);
      b_data = 16'(tb_b[i % N_OUT]);
      @(negedge clk);
    end
    w_we = 1'b0;
    b_we = 1'b0;
  endtask

  task automatic start_run(input bit push);
    for (int i = 0; i < N_IN; i++) in_vec[i] = 16'(tb_x[i]);
    if (push) push_expected();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int cycles);
    cycles = 0;
    while (valid_a !== 1'b1 && cycles < BOUND) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    total_cnt++;
    if (valid_a !== 1'b1 || valid_l !== 1'b1)
      $display("FAIL %s valid timeout: valid=%b/%b after %0d cycles", name, valid_a, valid_l, cycles);
    else pass_cnt++;
  endtask

  task automatic release_out(input string name);
    ready = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({valid_a, busy_a, valid_l, busy_l} !== 4'b0000)
      $display("FAIL %s release: valid/busy got %b%b%b%b expected 0000", name, valid_a, busy_a, valid_l, busy_l);
    else pass_cnt++;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic set_functional();
    for (int i = 0; i < N_IN; i++) tb_x[i] = func_x[i];
    for (int j = 0; j < N_OUT*N_IN; j++) tb_w[j] = (j < N_IN) ? 256 : 0;
    for (int o = 0; o < N_OUT; o++) tb_b[o] = o;
  endtask

  task automatic test_reset();
    int nz;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    total_cnt++;
    if ({valid_a, busy_a, sat_a, valid_l, busy_l, sat_l} !== 6'b0)
      $display("FAIL reset flags: got %b%b%b %b%b%b expected all 0", valid_a, busy_a, sat_a, valid_l, busy_l, sat_l);
    else pass_cnt++;
    nz = 0;
    for (int o = 0; o < N_OUT; o++) if (out_a[o] !== 16'sd0 || out_l[o] !== 16'sd0) nz++;
    total_cnt++;
    if (nz !== 0) $display("FAIL reset outputs: got %0d nonzero outputs expected 0", nz);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_functional();
    int cyc;
    set_functional();
    load_coeffs();
    start_run(1'b1);
    wait_valid("functional", cyc);
    total_cnt++;
    if (cyc !== 400) $display("FAIL functional latency: got %0d cycles expected 400", cyc);
    else pass_cnt++;
    scoreboard_compare("functional");
    total_cnt++;
    if (int'(out_a[0]) !== 3444 || int'(out_a[63]) !== 63)
      $display("FAIL functional values: got out[0]=%0d out[63]=%0d expected 3444 63", out_a[0], out_a[63]);
    else pass_cnt++;
    release_out("functional");
  endtask

  task automatic test_saturation();
    int cyc;
    for (int i = 0; i < N_IN; i++) tb_x[i] = 32767;
    for (int j = 0; j < N_OUT*N_IN; j++) tb_w[j] = 32767;
    for (int o = 0; o < N_OUT; o++) tb_b[o] = 0;
    load_coeffs();
    start_run(1'b1);
    wait_valid("sat_pos", cyc);
    scoreboard_compare("sat_pos");
    release_out("sat_pos");
    for (int j = 0; j < N_OUT*N_IN; j++) tb_w[j] = -32768;
    load_coeffs();
    start_run(1'b1);
    wait_valid("sat_neg", cyc);
    scoreboard_compare("sat_neg");
    total_cnt++;
    if (int'(out_l[7]) !== -32768 || int'(out_a[7]) !== 0 || sat_a !== 1'b1)
      $display("FAIL sat_neg values: got lin=%0d relu=%0d sat=%b expected -32768 0 1", out_l[7], out_a[7], sat_a);
    else pass_cnt++;
    release_out("sat_neg");
  endtask

  task automatic test_truncation();
    int cyc;
    for (int i = 0; i < N_IN; i++) tb_x[i] = 0;
    tb_x[0] = -1;
    for (int j = 0; j < N_OUT*N_IN; j++) tb_w[j] = 1;
    for (int o = 0; o < N_OUT; o++) tb_b[o] = 0;
    load_coeffs();
    start_run(1'b1);
    wait_valid("trunc_neg", cyc);
    scoreboard_compare("trunc_neg");
    total_cnt++;
    if (int'(out_l[0]) !== -1) $display("FAIL trunc_neg floor: got %0d expected -1", out_l[0]);
    else pass_cnt++;
    release_out("trunc_neg");
    tb_x[0] = 255;
    start_run(1'b1);
    wait_valid("trunc_pos", cyc);
    scoreboard_compare("trunc_pos");
    total_cnt++;
    if (int'(out_l[0]) !== 0) $display("FAIL trunc_pos: got %0d expected 0", out_l[0]);
    else pass_cnt++;
    release_out("trunc_pos");
  endtask

  task automatic test_handshake();
    int cyc;
    set_functional();
    load_coeffs();
    start_run(1'b1);
    repeat (50) @(negedge clk);
    // Writes to the last row and its bias mid-run must be dropped; tb_w/tb_b stay unchanged.
    for (int i = 0; i < N_IN; i++) begin
      w_we = 1'b1;
      w_addr = 11'((N_OUT - 1) * N_IN + i);
      w_data = 16'sd5;
      b_we = 1'b1;
      b_addr = 6'(N_OUT - 1);
      b_data = 16'sd100;
      start = (i == 5);
      @(negedge clk);
    end
    w_we = 1'b0;
    b_we = 1'b0;
    start = 1'b0;
    wait_valid("handshake", cyc);
    for (int c = 0; c < 1000; c++) begin
      start = (c % 100 == 50);
      @(negedge clk);
      if (c % 100 == 99) begin
        total_cnt++;
        if ({valid_a, busy_a, valid_l, busy_l} !== 4'b1111)
          $display("FAIL handshake hold c=%0d: valid/busy got %b%b%b%b expected 1111", c, valid_a, busy_a, valid_l, busy_l);
        else pass_cnt++;
      end
    end
    start = 1'b0;
    scoreboard_compare("handshake_hold");
    start = 1'b1;
    release_out("handshake_release");
    start = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (busy_a !== 1'b0 || busy_l !== 1'b0)
      $display("FAIL handshake start-on-release: busy got %b/%b expected 0", busy_a, busy_l);
    else pass_cnt++;
    start_run(1'b1);
    wait_valid("handshake_rerun", cyc);
    scoreboard_compare("handshake_rerun");
    release_out("handshake_rerun");
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int nz;
    set_functional();
    start_run(1'b0);
    repeat (100) @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({valid_a, busy_a, valid_l, busy_l} !== 4'b0000)
      $display("FAIL midrun reset flags: got %b%b%b%b expected 0000", valid_a, busy_a, valid_l, busy_l);
    else pass_cnt++;
    nz = 0;
    for (int o = 0; o < N_OUT; o++) if (out_a[o] !== 16'sd0 || out_l[o] !== 16'sd0) nz++;
    total_cnt++;
    if (nz !== 0) $display("FAIL midrun reset outputs: got %0d nonzero expected 0", nz);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_run(1'b1);
    wait_valid("after_reset", cyc);
    scoreboard_compare("after_reset");
    total_cnt++;
    if (int'(out_a[0]) !== 3444 || int'(out_l[5]) !== 5)
      $display("FAIL after_reset values: got out[0]=%0d out[5]=%0d expected 3444 5", out_a[0], out_l[5]);
    else pass_cnt++;
    release_out("after_reset");
  endtask

  initial begin
    for (int i = 0; i < N_IN; i++) in_vec[i] = '0;
    test_reset();
    test_functional();
    test_saturation();
    test_truncation();
    test_handshake();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
